decoder_sel_sequencer: RTL and testbench

- Sequential select generator that sits directly upstream of the 3-to-8 decoder.
- Steps a 3-bit select code through a programmed range, holding each code for a programmable dwell time, so the decoder's eight one-hot outputs are scanned in order.
- Supports one-shot and continuous scanning, up or down direction, and a qualifying `active` output for gating downstream loads.

---
 rtl/decoder_sel_sequencer.sv | 131 +++++++++++++
 tb/tb_decoder_sel_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_sel_sequencer.sv
// Select-code sequencer feeding the 3-to-8 decoder: scans sel through a latched
// range with a per-code dwell, one-shot or continuous, up or down.
module decoder_sel_sequencer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode_cont,
  input  logic               dir,
  input  logic [2:0]         first,
  input  logic [2:0]         last,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  output logic               active,
  output logic               step,
  output logic               done,
  output logic               busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic               active_q, active_d;
  logic               step_q, step_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [2:0]         first_q, first_d;
  logic [2:0]         last_q, last_d;
  logic               dir_q, dir_d;
  logic               cont_q, cont_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      active_q <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      first_q  <= '0;
      last_q   <= '0;
      dir_q    <= 1'b0;
      cont_q   <= 1'b0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      active_q <= active_d;
      step_q   <= step_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      last_q   <= last_d;
      dir_q    <= dir_d;
      cont_q   <= cont_d;
      dwell_q  <= dwell_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    active_d = active_q;
    step_d   = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    last_d   = last_q;
    dir_d    = dir_q;
    cont_d   = cont_q;
    dwell_d  = dwell_q;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          first_d  = first;
          last_d   = last;
          dir_d    = dir;
          cont_d   = mode_cont;
          dwell_d  = dwell;
          cnt_d    = '0;
          sel_d    = first;
          active_d = 1'b1;
          busy_d   = 1'b1;
          step_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          active_d = 1'b0;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else if (cnt_q != dwell_q) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (sel_q != last_q) begin
            sel_d  = dir_q ? sel_q - 3'd1 : sel_q + 3'd1;
            step_d = 1'b1;
          end else if (cont_q) begin
            sel_d  = first_q;
            step_d = 1'b1;
          end else begin
            // one-shot end: sel keeps showing last while done pulses
            done_d   = 1'b1;
            active_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel    = sel_q;
  assign active = active_q;
  assign step   = step_q;
  assign done   = done_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_decoder_sel_sequencer.sv
// Bench for decoder_sel_sequencer: directed scenarios plus random stimulus,
// checked against a time-since-start model of the scan.
module tb_decoder_sel_sequencer;

  localparam int unsigned DWELL_W = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, stop, mode_cont, dir;
  logic [2:0]         first, last;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         sel;
  logic               active, step, done, busy;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: configuration plus cycles elapsed since the accepted start
  bit       m_run;
  int       m_t, m_n, m_dw;
  bit [2:0] m_first, m_last, m_sel;
  bit       m_dir, m_cont, m_done;

  decoder_sel_sequencer #(.DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .mode_cont(mode_cont), .dir(dir), .first(first), .last(last),
    .dwell(dwell), .sel(sel), .active(active), .step(step),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_t = 0; m_n = 1; m_dw = 0;
    m_first = '0; m_last = '0; m_sel = '0;
    m_dir = 0; m_cont = 0; m_done = 0;
  endtask

  function automatic bit [2:0] model_code(int t);
    int k;
    k = t / (m_dw + 1);
    if (m_cont) k = k % m_n;
    return m_dir ? 3'((int'(m_first) - k) & 7) : 3'((int'(m_first) + k) & 7);
  endfunction

  task automatic model_edge();
    m_done = 0;
    if (!rst_n) begin
      model_reset();
    end else if (!m_run) begin
      if (start && !stop) begin
        m_first = first; m_last = last; m_dir = dir; m_cont = mode_cont;
        m_dw = int'(dwell); m_t = 0; m_run = 1;
        m_n = m_dir ? ((int'(first) - int'(last) + 8) % 8) + 1
                    : ((int'(last) - int'(first) + 8) % 8) + 1;
      end
    end else if (stop) begin
      m_run = 0;
    end else begin
      m_t++;
      if (!m_cont && m_t == m_n * (m_dw + 1)) begin
        m_run  = 0;
        m_done = 1;
      end
    end
    if (m_run) m_sel = model_code(m_t);
  endtask

  task automatic compare_all(input string where);
    bit e_step;
    e_step = m_run && (m_t % (m_dw + 1) == 0);
    check({where, ".sel"},    32'(sel),    32'(m_sel));
    check({where, ".active"}, 32'(active), 32'(m_run));
    check({where, ".busy"},   32'(busy),   32'(m_run));
    check({where, ".step"},   32'(step),   32'(e_step));
    check({where, ".done"},   32'(done),   32'(m_done));
  endtask

  task automatic tick(input string where);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(where);
  endtask

  task automatic set_cfg(input bit [2:0] f, input bit [2:0] l, input bit d,
                         input bit c, input bit [DWELL_W-1:0] dw);
    first = f; last = l; dir = d; mode_cont = c; dwell = dw;
  endtask

  task automatic pulse_start(input string where);
    start = 1'b1;
    tick(where);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; stop = 0;
    set_cfg(0, 0, 0, 0, 0);
    model_reset();
    #1;
    compare_all("reset");
    repeat (2) tick("reset_hold");
    @(negedge clk) rst_n = 1'b1;
    tick("post_reset");

    // one-shot up 2..5, dwell 1: 2,2,3,3,4,4,5,5 then done
    set_cfg(2, 5, 0, 0, 1);
    pulse_start("up_start");
    check("up_first_sel", 32'(sel), 32'd2);
    repeat (8) tick("up_scan");
    check("up_done_pulse", 32'(done), 32'd1);
    tick("up_after");

    // one-shot down with wrap 1..6, dwell 0: 1,0,7,6
    set_cfg(1, 6, 1, 0, 0);
    pulse_start("down_start");
    repeat (4) tick("down_scan");
    check("down_done_pulse", 32'(done), 32'd1);
    tick("down_after");

    // continuous 6..1 up, dwell 2, then stop
    set_cfg(6, 1, 0, 1, 2);
    pulse_start("cont_start");
    repeat (20) tick("cont_run");
    stop = 1'b1;
    tick("cont_stop");
    stop = 1'b0;
    repeat (3) tick("cont_idle");

    // single code with a redundant start while busy
    set_cfg(4, 4, 0, 0, 3);
    pulse_start("single_start");
    set_cfg(0, 7, 1, 1, 9);
    start = 1'b1;
    tick("single_restart");
    start = 1'b0;
    repeat (4) tick("single_scan");
    start = 1'b1; stop = 1'b1;
    tick("start_and_stop");
    start = 1'b0; stop = 1'b0;
    check("start_stop_busy", 32'(busy), 32'd0);

    // async reset mid-scan at sel=3, long dwell
    set_cfg(3, 7, 0, 0, 255);
    pulse_start("long_start");
    repeat (5) tick("long_hold");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_reset");
    tick("reset_low");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) tick("reset_released");

    // random stimulus, configuration shuffled every cycle
    for (int i = 0; i < 4000; i++) begin
      start     = ($urandom_range(0, 5) == 0);
      stop      = ($urandom_range(0, 39) == 0);
      mode_cont = ($urandom_range(0, 3) == 0);
      dir       = $urandom_range(0, 1);
      first     = 3'($urandom_range(0, 7));
      last      = 3'($urandom_range(0, 7));
      dwell     = ($urandom_range(0, 9) == 0) ? DWELL_W'($urandom_range(4, 12))
                                             : DWELL_W'($urandom_range(0, 3));
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
